// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states and
// op classification helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_store(input op_t op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction

    // Natural alignment: words on 4-byte, halfwords on 2-byte boundaries.
    function automatic logic misaligned(input op_t op, input logic [1:0] addr_lo);
        case (op)
            OP_LW, OP_SW:         return addr_lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return addr_lo[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane steering: store byte-enables/replication and load
// byte/halfword extraction with sign or zero extension.
module lsu_lane
    import lsu_pkg::*;
(
    input  op_t         op_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] ld_ext
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: enables and replicated write data for the addressed lanes.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (op_type)
            OP_SB: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            OP_SH: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed byte/halfword and extend it.
    always_comb begin
        shifted  = rdata >> {addr_lo, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (op_type)
            OP_LB:   ld_ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_ext = {24'h0, byte_sel};
            OP_LH:   ld_ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ld_ext = {16'h0, half_sel};
            default: ld_ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit: accepts one op, runs a req/gnt/rvalid
// handshake, and retires it with a single done or err pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] ld_data,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    state_t      state, state_nx;
    op_t         op_in, op_q;
    logic [31:0] addr_q, wdata_q, ld_q, ld_ext;
    logic        err_q, illegal, take, reject;

    assign op_in   = op_t'(op_type);
    assign illegal = misaligned(op_in, op_addr[1:0])
                   || (((op_addr - ADDR_BASE) >> 2) >= MEM_WORDS);

    // Next state and state-decoded outputs. The err cycle is IDLE with the
    // faulting op still presented; err_q blocks re-acceptance and drops stall
    // so the pipeline retires it exactly once.
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        reject   = 1'b0;
        stall    = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_valid && !err_q) begin
                    stall = 1'b1;
                    if (illegal) begin
                        reject = 1'b1;
                    end else begin
                        take     = 1'b1;
                        state_nx = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = is_store(op_q);
                if (mem_gnt) state_nx = is_store(op_q) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Latch the accepted op so memory-side outputs stay constant until gnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            op_q    <= op_in;
            addr_q  <= op_addr;
            wdata_q <= op_wdata;
        end
    end

    // One-cycle error pulse following a rejected op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= reject;
    end

    // Load result register, updated only when read data arrives in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            ld_q <= '0;
        else if (state == ST_WAIT && mem_rvalid) ld_q <= ld_ext;
    end

    lsu_lane u_lane (
        .op_type   (op_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .be        (mem_be),
        .wdata_rep (mem_wdata),
        .ld_ext    (ld_ext)
    );

    assign err      = err_q;
    assign ld_data  = ld_q;
    assign mem_addr = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: the driver pushes expected memory phases and
// responses; a bus responder and a response monitor pop and compare.
module tb_lsu;
    import lsu_pkg::*;

    localparam int unsigned WORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_type;
    logic [31:0] op_addr, op_wdata;
    logic        stall, done, err, mem_req, mem_we;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    lsu #(.MEM_WORDS(WORDS), .ADDR_BASE(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
        .op_addr(op_addr), .op_wdata(op_wdata), .stall(stall), .done(done),
        .ld_data(ld_data), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } mexp_t;

    typedef struct {
        string       name;
        logic        is_err;
        logic        chk_ld;
        logic [31:0] ld;
        int          due;
    } rexp_t;

    mexp_t mq[$];
    rexp_t rq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int grants = 0;
    int gnt_dly = 0;
    int wcnt = 0;
    logic hold_rv = 1'b0;
    logic rv_force = 1'b0;
    logic rv_pend = 1'b0;
    logic [31:0] rd_word = '0;
    logic [31:0] mem_model [WORDS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Bus responder: grants after gnt_dly cycles, checks the request against
    // the expected memory phase, applies writes and returns read data.
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (reset) begin
                wcnt = 0;
                rv_pend = 1'b0;
            end else if (rv_force) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
                rv_force   = 1'b0;
            end else if (rv_pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_word;
                rv_pend    = 1'b0;
            end else if (mem_req) begin
                if (mq.size() == 0) begin
                    chk("unexpected_req", 32'(mem_req), 32'd0);
                end else if (wcnt < gnt_dly) begin
                    wcnt++;
                    chk("hold_addr", mem_addr, mq[0].addr);
                    chk("hold_be", 32'(mem_be), 32'(mq[0].be));
                end else begin
                    mexp_t m;
                    m = mq.pop_front();
                    wcnt = 0;
                    mem_gnt = 1'b1;
                    grants++;
                    chk("req_we", 32'(mem_we), 32'(m.we));
                    chk("req_addr", mem_addr, m.addr);
                    chk("req_be", 32'(mem_be), 32'(m.be));
                    if (m.we) begin
                        chk("req_wdata", mem_wdata, m.wd);
                        for (int unsigned b = 0; b < 4; b++)
                            if (mem_be[b]) mem_model[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    end else if (!hold_rv) begin
                        rv_pend = 1'b1;
                        rd_word = mem_model[mem_addr[7:2]];
                    end
                end
            end
        end
    end

    // Response monitor: every done/err pulse must match the queue head.
    always @(negedge clk) begin
        if (!reset && (done || err)) begin
            if (rq.size() == 0) begin
                chk("unexpected_resp", {30'd0, done, err}, 32'd0);
            end else begin
                rexp_t r;
                r = rq.pop_front();
                chk({r.name, "_err"}, 32'(err), 32'(r.is_err));
                chk({r.name, "_done"}, 32'(done), 32'(!r.is_err));
                if (r.chk_ld) chk({r.name, "_ld"}, ld_data, r.ld);
                if (r.due >= 0) chk({r.name, "_lat"}, cyc, r.due);
            end
        end
    end

    // Present one op (entered and left at posedge+1) and hold it while stalled.
    task automatic issue(input string nm, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input int gd, input logic is_err,
                         input logic [3:0] be, input logic [31:0] mwd,
                         input logic [31:0] ld, input int lat);
        rexp_t r;
        mexp_t m;
        logic  retired;
        r.name = nm; r.is_err = is_err; r.chk_ld = !is_err && (t < 3'd5);
        r.ld = ld; r.due = (lat < 0) ? -1 : cyc + lat;
        rq.push_back(r);
        if (!is_err) begin
            m.we = (t >= 3'd5); m.addr = {a[31:2], 2'b00}; m.be = be; m.wd = mwd;
            mq.push_back(m);
        end
        gnt_dly = gd;
        op_type = t; op_addr = a; op_wdata = wd; op_valid = 1'b1;
        retired = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) begin
                retired = 1'b1;
                chk({nm, "_retire"}, 32'(done | err), 32'd1);
                break;
            end
        end
        if (!retired) chk({nm, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        for (int unsigned i = 0; i < WORDS; i++) mem_model[i] = '0;
        reset = 1'b1; op_valid = 1'b0; op_type = '0; op_addr = '0; op_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ld", ld_data, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Stores
        issue("sb3",  OP_SB, 32'h0000_0003, 32'h1234_56AB, 0, 1'b0, 4'b1000, 32'hABAB_ABAB, 32'h0, 2);
        issue("sh6",  OP_SH, 32'h0000_0006, 32'h0000_BEEF, 1, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0, 3);
        issue("sb1",  OP_SB, 32'h0000_0021, 32'h0000_0077, 0, 1'b0, 4'b0010, 32'h7777_7777, 32'h0, 2);
        // Back-to-back store then load to 0x10
        issue("sw10", OP_SW, 32'h0000_0010, 32'hCAFE_F00D, 0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0, 2);
        issue("lw10", OP_LW, 32'h0000_0010, 32'h0, 0, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D, 3);

        // Loads with hand-computed extraction
        mem_model[1]  = 32'h8001_7FFF;
        mem_model[0]  = 32'h0000_F000;
        mem_model[63] = 32'h1357_9BDF;
        issue("lh6",  OP_LH,  32'h0000_0006, 32'h0, 3, 1'b0, 4'b1111, 32'h0, 32'hFFFF_8001, 6);
        issue("lhu4", OP_LHU, 32'h0000_0004, 32'h0, 0, 1'b0, 4'b1111, 32'h0, 32'h0000_7FFF, 3);
        issue("lbu1", OP_LBU, 32'h0000_0001, 32'h0, 0, 1'b0, 4'b1111, 32'h0, 32'h0000_00F0, 3);
        issue("lb1",  OP_LB,  32'h0000_0001, 32'h0, 0, 1'b0, 4'b1111, 32'h0, 32'hFFFF_FFF0, 3);
        issue("lb6",  OP_LB,  32'h0000_0006, 32'h0, 2, 1'b0, 4'b1111, 32'h0, 32'h0000_0001, 5);
        issue("lwtop", OP_LW, 32'h0000_00FC, 32'h0, 0, 1'b0, 4'b1111, 32'h0, 32'h1357_9BDF, 3);

        // Illegal ops: err next cycle, no memory request
        issue("sw2",   OP_SW,  32'h0000_0002, 32'h1111_1111, 0, 1'b1, 4'b0, 32'h0, 32'h0, 1);
        issue("lwoor", OP_LW,  32'h0000_0100, 32'h0, 0, 1'b1, 4'b0, 32'h0, 32'h0, 1);
        issue("lh3",   OP_LH,  32'h0000_0003, 32'h0, 0, 1'b1, 4'b0, 32'h0, 32'h0, 1);
        issue("shoor", OP_SH,  32'h0000_0102, 32'h0, 0, 1'b1, 4'b0, 32'h0, 32'h0, 1);

        // Reset while waiting for read data; late rvalid must be ignored.
        begin
            mexp_t m;
            int    g0;
            logic  granted;
            hold_rv = 1'b1;
            gnt_dly = 0;
            m.we = 1'b0; m.addr = 32'h0000_0010; m.be = 4'b1111; m.wd = '0;
            mq.push_back(m);
            g0 = grants;
            op_type = OP_LW; op_addr = 32'h0000_0010; op_wdata = '0; op_valid = 1'b1;
            granted = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (grants != g0) begin
                    granted = 1'b1;
                    break;
                end
            end
            chk("rstw_granted", 32'(granted), 32'd1);
            @(posedge clk); #1;
            reset = 1'b1;
            op_valid = 1'b0;
            #1;
            chk("rstw_stall", 32'(stall), 32'd0);
            chk("rstw_req", 32'(mem_req), 32'd0);
            chk("rstw_done", 32'(done), 32'd0);
            chk("rstw_ld", ld_data, 32'd0);
            @(posedge clk); #1;
            reset = 1'b0;
            hold_rv = 1'b0;
            rv_force = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("rstw_ld_after", ld_data, 32'd0);
            chk("rstw_idle_stall", 32'(stall), 32'd0);
            chk("rstw_idle_req", 32'(mem_req), 32'd0);
        end

        issue("lw10b", OP_LW, 32'h0000_0010, 32'h0, 0, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D, 3);

        repeat (4) @(posedge clk);
        #1;
        chk("rq_drained", rq.size(), 32'd0);
        chk("mq_drained", mq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
